// File: rtl/shift_pkg.sv
// Shared types and default sizes for the iterative shift unit.
package shift_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_AMT_W = 4;

  typedef enum logic [1:0] {SH_PASS, SH_LSL, SH_LSR, SH_ASR} shift_op_t;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} shift_state_t;

endpackage

// File: rtl/shift_step.sv
// Single 1-bit shift step; purely combinational, used in the result feedback path.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] in,
  input  shift_op_t        op,
  output logic [WIDTH-1:0] out
);

  // NOTE: out is assigned before the case so every path drives it and no latch is inferred.
  always_comb begin
    out = in;
    case (op)
      SH_LSL:  out = {in[WIDTH-2:0], 1'b0};
      SH_LSR:  out = {1'b0, in[WIDTH-1:1]};
      SH_ASR:  out = {in[WIDTH-1], in[WIDTH-1:1]};
      default: out = in;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle LSL/LSR/ASR unit: one bit position per clock, start/busy/done handshake.
module iter_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sout
);

  shift_state_t     state, state_next;
  shift_op_t        op_r;
  logic [AMT_W-1:0] count;
  logic             accept;
  logic [WIDTH-1:0] step_out;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .in  (sout),
    .op  (op_r),
    .out (step_out)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (shift_op_t'(op) == SH_PASS || amt == '0) ? ST_DONE : ST_SHIFT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (count == AMT_W'(1)) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // busy/done are flopped from the next state so they leave the unit glitch-free.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sout  <= '0;
      op_r  <= SH_PASS;
      count <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_SHIFT);
      done  <= (state_next == ST_DONE);
      if (accept) begin
        sout  <= in;
        op_r  <= shift_op_t'(op);
        count <= amt;
      end else if (state == ST_SHIFT) begin
        sout  <= step_out;
        count <= count - AMT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
// Directed self-checking bench for iter_shifter with hand-computed expected results.
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] in_d = '0;
  logic [1:0]  op = '0;
  logic [3:0]  amt = '0;
  logic        busy;
  logic        done;
  logic [15:0] sout;

  int n_checks = 0;
  int n_errors = 0;

  iter_shifter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in    (in_d),
    .op    (op),
    .amt   (amt),
    .busy  (busy),
    .done  (done),
    .sout  (sout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done, counting busy cycles seen on the way.
  task automatic wait_done(output bit seen, output int bsy);
    seen = 1'b0;
    bsy  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) bsy++;
        tick();
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [1:0] o,
                        input logic [3:0] n, input logic [15:0] exp, input int exp_busy);
    bit seen;
    int bsy;
    start = 1'b1; in_d = a; op = o; amt = n;
    tick();
    start = 1'b0; in_d = ~a; op = ~o; amt = ~n;
    wait_done(seen, bsy);
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, 32'(bsy), 32'(exp_busy));
    check({tag, "_sout"}, 32'(sout), 32'(exp));
    tick();
    check({tag, "_done_single"}, 32'(done), 32'd0);
  endtask

  initial begin
    bit seen;
    int bsy;
    int cnt;

    // Reset values
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sout", 32'(sout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset mid-operation: must clear outputs without a clock edge
    start = 1'b1; in_d = 16'h0001; op = 2'b01; amt = 4'd5;
    tick();
    start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sout", 32'(sout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) cnt++;
    end
    check("midrst_no_activity", 32'(cnt), 32'd0);

    // LSL by 4, then hold through idle
    run_op("lsl4", 16'h0001, 2'b01, 4'd4, 16'h0010, 4);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (sout !== 16'h0010) cnt++;
    end
    check("lsl4_hold", 32'(cnt), 32'd0);

    // Boundary: 15-step shifts of the sign bit
    run_op("asr15", 16'h8000, 2'b11, 4'd15, 16'hFFFF, 15);
    run_op("lsr15", 16'h8000, 2'b10, 4'd15, 16'h0001, 15);
    run_op("lsl15", 16'h0001, 2'b01, 4'd15, 16'h8000, 15);
    run_op("asr3_pos", 16'h4321, 2'b11, 4'd3, 16'h0864, 3);

    // Zero amount and pass-through complete without busy
    run_op("amt0", 16'hA5A5, 2'b01, 4'd0, 16'hA5A5, 0);
    run_op("pass", 16'h1234, 2'b00, 4'd7, 16'h1234, 0);

    // start during SHIFT is ignored
    start = 1'b1; in_d = 16'hF000; op = 2'b10; amt = 4'd3;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; in_d = 16'h0001; op = 2'b01; amt = 4'd0;
    tick();
    start = 1'b0;
    wait_done(seen, bsy);
    check("ign_done", 32'(seen), 32'd1);
    check("ign_sout", 32'(sout), 32'h1E00);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) cnt++;
    end
    check("ign_single_done", 32'(cnt), 32'd0);

    // Back-to-back: start held into DONE restarts the same operation
    start = 1'b1; in_d = 16'h0003; op = 2'b01; amt = 4'd2;
    tick();
    wait_done(seen, bsy);
    check("b2b_first_done", 32'(seen), 32'd1);
    check("b2b_first_sout", 32'(sout), 32'h000C);
    tick();
    start = 1'b0;
    check("b2b_restart_busy", 32'(busy), 32'd1);
    check("b2b_restart_sout", 32'(sout), 32'h0003);
    wait_done(seen, bsy);
    check("b2b_second_done", 32'(seen), 32'd1);
    check("b2b_shift_cycles", 32'(bsy), 32'd2);
    check("b2b_second_sout", 32'(sout), 32'h000C);
    tick();
    check("b2b_done_single", 32'(done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
